// File: rtl/mem_arbiter_6502_if.sv
// Bus bundle between two requesters (A: cache, B: DMA/video), the arbiter and memory.
// The arbiter sits on the slave modport; the requester/memory side drives through master.
interface mem_arbiter_6502_if #(
  parameter int ADDR_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_en;
  logic                  a_wr;
  logic                  a_rburst;
  logic [7:0]            a_wdata;
  logic                  a_rdy;
  logic                  a_rdata_load;
  logic                  a_gnt;

  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  b_en;
  logic                  b_wr;
  logic                  b_rburst;
  logic [7:0]            b_wdata;
  logic                  b_rdy;
  logic                  b_rdata_load;
  logic                  b_gnt;

  logic [7:0]            rdata0;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_en;
  logic                  mem_wr;
  logic                  mem_rburst;
  logic [7:0]            mem_wdata;
  logic                  mem_rdy;
  logic                  mem_rdata_load;
  logic [7:0]            mem_rdata0;

  modport slave (
    input  a_addr, a_en, a_wr, a_rburst, a_wdata,
    output a_rdy, a_rdata_load, a_gnt,
    input  b_addr, b_en, b_wr, b_rburst, b_wdata,
    output b_rdy, b_rdata_load, b_gnt,
    output rdata0,
    output mem_addr, mem_en, mem_wr, mem_rburst, mem_wdata,
    input  mem_rdy, mem_rdata_load, mem_rdata0
  );

  modport master (
    output a_addr, a_en, a_wr, a_rburst, a_wdata,
    input  a_rdy, a_rdata_load, a_gnt,
    output b_addr, b_en, b_wr, b_rburst, b_wdata,
    input  b_rdy, b_rdata_load, b_gnt,
    input  rdata0,
    input  mem_addr, mem_en, mem_wr, mem_rburst, mem_wdata,
    output mem_rdy, mem_rdata_load, mem_rdata0
  );
endinterface

// File: rtl/mem_arbiter_6502.sv
// Two-port memory arbiter: grants one requester at a time, holds the grant until the
// final mem_rdata_load beat of its single or burst transaction, then returns to IDLE.
module mem_arbiter_6502 #(
  parameter int ADDR_WIDTH = 24,
  parameter int BURST_LEN  = 16,
  parameter int PRIO_A     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_arbiter_6502_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_A = 2'd1, GNT_B = 2'd2} state_t;

  localparam logic [3:0] LAST_BURST_BEAT = 4'(BURST_LEN - 1);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_beat;
  logic                  r_last_b;
  logic                  r_burst;

  logic                  w_granted;
  logic                  w_last_beat;
  logic                  w_pick_a;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_en;
  logic                  w_wr;
  logic                  w_rburst;
  logic [7:0]            w_wdata;
  logic                  w_a_gnt;
  logic                  w_a_rdy;
  logic                  w_a_load;
  logic                  w_b_gnt;
  logic                  w_b_rdy;
  logic                  w_b_load;

  // Stage boundary: arbitration / next-state decode
  always_comb begin
    w_granted   = (r_state != IDLE);
    w_last_beat = w_granted && bus.mem_rdata_load &&
                  (r_beat == (r_burst ? LAST_BURST_BEAT : 4'd0));
    // On a tie, fixed priority gives A; otherwise A wins only if B was served last.
    w_pick_a    = bus.a_en && (!bus.b_en || (PRIO_A != 0) || r_last_b);
    w_next      = r_state;
    case (r_state)
      IDLE:         if (bus.a_en || bus.b_en) w_next = w_pick_a ? GNT_A : GNT_B;
      GNT_A, GNT_B: if (w_last_beat) w_next = IDLE;
      default:      w_next = IDLE;
    endcase
  end

  // Stage boundary: state, beat counter and fairness history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_beat   <= 4'd0;
      r_last_b <= 1'b1;
      r_burst  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (w_next == GNT_A) begin
          r_beat  <= 4'd0;
          r_burst <= bus.a_rburst & ~bus.a_wr;
        end else if (w_next == GNT_B) begin
          r_beat  <= 4'd0;
          r_burst <= bus.b_rburst & ~bus.b_wr;
        end
      end else if (bus.mem_rdata_load) begin
        r_beat <= r_beat + 4'd1;
      end
      if (w_last_beat) r_last_b <= (r_state == GNT_B);
    end
  end

  // Stage boundary: combinational routing of the owning port onto the memory bus
  always_comb begin
    w_addr   = '0;
    w_en     = 1'b0;
    w_wr     = 1'b0;
    w_rburst = 1'b0;
    w_wdata  = 8'h00;
    w_a_gnt  = 1'b0;
    w_a_rdy  = 1'b0;
    w_a_load = 1'b0;
    w_b_gnt  = 1'b0;
    w_b_rdy  = 1'b0;
    w_b_load = 1'b0;
    case (r_state)
      GNT_A: begin
        w_addr   = bus.a_addr;
        w_en     = bus.a_en;
        w_wr     = bus.a_wr;
        w_rburst = bus.a_rburst;
        w_wdata  = bus.a_wdata;
        w_a_gnt  = 1'b1;
        w_a_rdy  = bus.mem_rdy;
        w_a_load = bus.mem_rdata_load;
      end
      GNT_B: begin
        w_addr   = bus.b_addr;
        w_en     = bus.b_en;
        w_wr     = bus.b_wr;
        w_rburst = bus.b_rburst;
        w_wdata  = bus.b_wdata;
        w_b_gnt  = 1'b1;
        w_b_rdy  = bus.mem_rdy;
        w_b_load = bus.mem_rdata_load;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr     = w_addr;
  assign bus.mem_en       = w_en;
  assign bus.mem_wr       = w_wr;
  assign bus.mem_rburst   = w_rburst;
  assign bus.mem_wdata    = w_wdata;
  assign bus.a_gnt        = w_a_gnt;
  assign bus.a_rdy        = w_a_rdy;
  assign bus.a_rdata_load = w_a_load;
  assign bus.b_gnt        = w_b_gnt;
  assign bus.b_rdy        = w_b_rdy;
  assign bus.b_rdata_load = w_b_load;
  assign bus.rdata0       = bus.mem_rdata0;

endmodule

// File: tb/tb_mem_arbiter_6502.sv
// Directed bench for mem_arbiter_6502 (round-robin build, 16-beat bursts).
`timescale 1ns/1ps
module tb_mem_arbiter_6502;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   pulses;
  logic exp_a;

  always #5 clk = ~clk;

  mem_arbiter_6502_if #(.ADDR_WIDTH(24)) bus ();

  mem_arbiter_6502 #(
    .ADDR_WIDTH (24),
    .BURST_LEN  (16),
    .PRIO_A     (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.a_addr = '0; bus.a_en = 0; bus.a_wr = 0; bus.a_rburst = 0; bus.a_wdata = 8'h00;
    bus.b_addr = '0; bus.b_en = 0; bus.b_wr = 0; bus.b_rburst = 0; bus.b_wdata = 8'h00;
    bus.mem_rdy = 0; bus.mem_rdata_load = 0; bus.mem_rdata0 = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // Reset: outputs quiet even with memory strobes and a request present
    bus.mem_rdy = 1; bus.mem_rdata_load = 1; bus.a_en = 1;
    #2;
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_a_gnt", bus.a_gnt, 0);
    chk("rst_b_gnt", bus.b_gnt, 0);
    chk("rst_a_rdy", bus.a_rdy, 0);
    chk("rst_b_rdy", bus.b_rdy, 0);
    chk("rst_a_load", bus.a_rdata_load, 0);
    chk("rst_b_load", bus.b_rdata_load, 0);
    cyc();
    chk("rst_hold_a_gnt", bus.a_gnt, 0);
    bus.a_en = 0; bus.mem_rdy = 0; bus.mem_rdata_load = 0; rst_n = 1;
    bus.mem_rdata0 = 8'hA5;
    #1;
    chk("rdata0_bcast", bus.rdata0, 8'hA5);
    cyc();

    // Round-robin ties: A,B,A,B,A,B with an idle cycle between grants
    bus.a_addr = 24'h000010; bus.b_addr = 24'h000020;
    bus.a_en = 1; bus.b_en = 1;
    cyc();
    for (int k = 0; k < 6; k++) begin
      exp_a = (k % 2 == 0);
      #2;
      chk("rr_a_gnt", bus.a_gnt, exp_a);
      chk("rr_b_gnt", bus.b_gnt, !exp_a);
      chk("rr_addr", bus.mem_addr, exp_a ? 24'h000010 : 24'h000020);
      bus.mem_rdata_load = 1;
      #1;
      chk("rr_a_load", bus.a_rdata_load, exp_a);
      chk("rr_b_load", bus.b_rdata_load, !exp_a);
      cyc();
      bus.mem_rdata_load = 0;
      if (k == 5) begin bus.a_en = 0; bus.b_en = 0; end
      #2;
      chk("rr_idle_a", bus.a_gnt, 0);
      chk("rr_idle_b", bus.b_gnt, 0);
      chk("rr_idle_en", bus.mem_en, 0);
      cyc();
    end

    // Single read on A
    bus.a_addr = 24'h001234; bus.a_en = 1;
    #2;
    chk("s_pre_gnt", bus.a_gnt, 0);
    cyc();
    #2;
    chk("s_a_gnt", bus.a_gnt, 1);
    chk("s_mem_en", bus.mem_en, 1);
    chk("s_mem_addr", bus.mem_addr, 24'h001234);
    chk("s_mem_wr", bus.mem_wr, 0);
    bus.mem_rdata0 = 8'h5A; bus.mem_rdata_load = 1; bus.mem_rdy = 1;
    #1;
    chk("s_a_load", bus.a_rdata_load, 1);
    chk("s_a_rdy", bus.a_rdy, 1);
    chk("s_rdata0", bus.rdata0, 8'h5A);
    chk("s_b_load", bus.b_rdata_load, 0);
    bus.a_en = 0;
    cyc();
    bus.mem_rdata_load = 0; bus.mem_rdy = 0;
    #2;
    chk("s_end_gnt", bus.a_gnt, 0);
    chk("s_end_en", bus.mem_en, 0);

    // Stray beat while idle
    bus.mem_rdata_load = 1;
    #1;
    chk("idle_a_load", bus.a_rdata_load, 0);
    chk("idle_b_load", bus.b_rdata_load, 0);
    chk("idle_a_gnt", bus.a_gnt, 0);
    cyc();
    bus.mem_rdata_load = 0;

    // 16-beat burst on A, one gap mid-burst, en dropped on the final beat
    bus.a_addr = 24'h00F000; bus.a_rburst = 1; bus.a_en = 1;
    cyc();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        bus.mem_rdata_load = 0;
        #2;
        chk("b_gap_load", bus.a_rdata_load, 0);
        chk("b_gap_gnt", bus.a_gnt, 1);
        cyc();
      end
      bus.mem_rdata_load = 1;
      if (i == 15) bus.a_en = 0;
      #2;
      chk("b_gnt", bus.a_gnt, 1);
      if (bus.a_rdata_load) pulses++;
      if (i == 0) begin
        chk("b_rburst", bus.mem_rburst, 1);
        chk("b_addr", bus.mem_addr, 24'h00F000);
      end
      cyc();
    end
    bus.mem_rdata_load = 0; bus.a_rburst = 0;
    #2;
    chk("b_pulses", pulses, 16);
    chk("b_end_gnt", bus.a_gnt, 0);

    // B single write (rburst with wr is single); A waits with en high
    bus.b_addr = 24'h000200; bus.b_wr = 1; bus.b_rburst = 1; bus.b_wdata = 8'hC3; bus.b_en = 1;
    cyc();
    bus.a_en = 1; bus.a_addr = 24'h000300; bus.mem_rdy = 1;
    #2;
    chk("w_b_gnt", bus.b_gnt, 1);
    chk("w_a_gnt", bus.a_gnt, 0);
    chk("w_wdata", bus.mem_wdata, 8'hC3);
    chk("w_wr", bus.mem_wr, 1);
    chk("w_rburst", bus.mem_rburst, 1);
    chk("w_addr", bus.mem_addr, 24'h000200);
    chk("w_a_rdy", bus.a_rdy, 0);
    chk("w_b_rdy", bus.b_rdy, 1);
    cyc();
    bus.mem_rdata_load = 1;
    #2;
    chk("w_a_load", bus.a_rdata_load, 0);
    chk("w_b_load", bus.b_rdata_load, 1);
    chk("w_b_gnt2", bus.b_gnt, 1);
    bus.b_en = 0;
    cyc();
    bus.mem_rdata_load = 0; bus.mem_rdy = 0;
    #2;
    chk("w_end_b_gnt", bus.b_gnt, 0);
    chk("w_end_a_gnt", bus.a_gnt, 0);
    cyc();
    #2;
    chk("w_then_a_gnt", bus.a_gnt, 1);
    chk("w_then_a_wr", bus.mem_wr, 0);
    chk("w_then_a_addr", bus.mem_addr, 24'h000300);
    bus.mem_rdata_load = 1; bus.a_en = 0; bus.b_wr = 0; bus.b_rburst = 0;
    cyc();
    bus.mem_rdata_load = 0;

    // Reset after beat 7 of a burst
    bus.a_addr = 24'h000000; bus.a_rburst = 1; bus.a_en = 1;
    cyc();
    for (int i = 0; i < 7; i++) begin
      bus.mem_rdata_load = 1;
      cyc();
    end
    rst_n = 0;
    #2;
    chk("ra_mem_en", bus.mem_en, 0);
    chk("ra_a_gnt", bus.a_gnt, 0);
    chk("ra_a_load", bus.a_rdata_load, 0);
    cyc();
    rst_n = 1; bus.a_en = 0; bus.a_rburst = 0;
    #2;
    chk("ra_post_load", bus.a_rdata_load, 0);
    cyc();
    #2;
    chk("ra_post_load2", bus.a_rdata_load, 0);
    chk("ra_post_gnt", bus.a_gnt, 0);
    bus.mem_rdata_load = 0;
    bus.a_en = 1; bus.b_en = 1;
    cyc();
    #2;
    chk("ra_tie_a_gnt", bus.a_gnt, 1);
    chk("ra_tie_b_gnt", bus.b_gnt, 0);
    bus.mem_rdata_load = 1;
    #1;
    chk("ra_a_load1", bus.a_rdata_load, 1);
    bus.a_en = 0;
    cyc();
    bus.mem_rdata_load = 0;
    #2;
    chk("ra_single_end", bus.a_gnt, 0);
    cyc();
    #2;
    chk("ra_b_gnt", bus.b_gnt, 1);
    bus.mem_rdata_load = 1; bus.b_en = 0;
    cyc();
    bus.mem_rdata_load = 0;
    #2;
    chk("ra_b_end", bus.b_gnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_6502.md
MEM_ARBITER_6502 -- requirements
Module: mem_arbiter_6502

Interface
REQ-001 Parameter: ADDR_WIDTH, 24, width of all memory address buses.
REQ-002 Parameter: BURST_LEN, 16, number of mem_rdata_load beats in a read burst (power of two, 2..16).
REQ-003 Parameter: PRIO_A, 1, when 1 port A wins ties in IDLE; when 0 ties use round-robin.
REQ-004 The following ports SHALL be provided, clock and reset first:
  clk  input  1  single clock, all logic on posedge.
  rst_n  input  1  asynchronous, active-low reset.
  a_addr  input  ADDR_WIDTH  port A (cache side) address.
  a_en, a_wr, a_rburst  input  1 each  port A request, write, read-burst.
  a_wdata  input  8  port A write data.
  a_rdy, a_rdata_load  output  1 each  gated mem_rdy / mem_rdata_load for port A.
  a_gnt  output  1  port A owns memory.
  b_addr, b_en, b_wr, b_rburst, b_wdata  input  as port A  port B (DMA/video side) request.
  b_rdy, b_rdata_load, b_gnt  output  1 each  as port A.
  rdata0  output  8  mem_rdata0 broadcast to both ports.
  mem_addr  output  ADDR_WIDTH; mem_en, mem_wr, mem_rburst  output  1 each; mem_wdata  output  8.
  mem_rdy, mem_rdata_load  input  1 each; mem_rdata0  input  8.

Function
REQ-005 States SHALL be IDLE, GNT_A, GNT_B.
REQ-006 In IDLE, mem_en SHALL be 0, both gnt 0, both rdy 0, both rdata_load 0.
REQ-007 In IDLE with exactly one of a_en/b_en high, next state SHALL grant that port; with both high, port A if PRIO_A=1, else the port not granted last (last_gnt reset to B, so A wins first tie).
REQ-008 Grant latency: request seen in IDLE at cycle N -> gnt and mem_en high at cycle N+1.
REQ-009 At grant entry, the granted port's wr and rburst SHALL be latched; transaction type = burst iff rburst=1 and wr=0, else single.
REQ-010 While granted, mem_addr, mem_wr, mem_wdata, mem_en, mem_rburst SHALL pass through combinationally from the granted port; the other port has no effect.
REQ-011 While granted, x_rdy = mem_rdy and x_rdata_load = mem_rdata_load for the granted port only; the other port sees 0.
REQ-012 A 4-bit beat counter SHALL clear at grant entry and increment on each mem_rdata_load while granted.
REQ-013 Last beat = mem_rdata_load with counter == 0 (single) or == BURST_LEN-1 (burst); next state SHALL be IDLE and last_gnt updated.
REQ-014 Grant SHALL persist until last beat even if the granted port drops en mid-burst (cache drops en before final beat).
REQ-015 mem_rdata_load in IDLE SHALL be ignored (no counter change, no port load).
REQ-016 Requester new en in the last-beat cycle SHALL be arbitrated only after the mandatory IDLE cycle; back-to-back same-port transactions are separated by one idle cycle.
REQ-017 rdata0 SHALL equal mem_rdata0 at all times.
REQ-018 Burst with wr=1 SHALL be treated as a single write; mem_rburst passes through unchanged.

Reset
REQ-019 rst_n low SHALL asynchronously force state IDLE, beat counter 0, last_gnt B.
REQ-020 During and after reset until a grant: mem_en 0, a_gnt/b_gnt 0, a_rdy/b_rdy 0, a_rdata_load/b_rdata_load 0.
REQ-021 Reset asserted mid-burst SHALL abort the transaction; beats arriving after deassertion while IDLE are dropped.

Verification
REQ-022 a_en=1,a_wr=0,a_rburst=0,a_addr=0x001234 -> a_gnt next cycle, mem_addr=0x001234; one mem_rdata_load with mem_rdata0=0x5A -> a_rdata_load=1, rdata0=0x5A, IDLE next cycle.
REQ-023 a_rburst=1 at 0x00F000, a_en dropped after beat 15 -> grant held, exactly 16 a_rdata_load pulses, then IDLE.
REQ-024 a_en and b_en rise together, PRIO_A=0, three rounds -> grants A,B,A,B,A,B with one IDLE cycle between each.
REQ-025 b granted single write b_wdata=0xC3, a_en high throughout -> a_rdy=0, a_rdata_load=0 until b completes; mem_wdata=0xC3, mem_wr=1.
REQ-026 rst_n pulsed low after beat 7 of a burst -> mem_en 0 immediately, remaining beats ignored, next a_en granted normally with counter 0.
REQ-027 mem_rdata_load pulsed in IDLE -> no rdata_load on either port, counter unchanged.
